// File: rtl/mt_pkg.sv
// Shared definitions for the multi-slave MT drive-status bank.
package mt_pkg;

  localparam int NDRV_MAX = 8;

  // DS image bit positions, MSB first
  localparam int dsATA  = 15;
  localparam int dsERR  = 14;
  localparam int dsPIP  = 13;
  localparam int dsMOL  = 12;
  localparam int dsWRL  = 11;
  localparam int dsEOT  = 10;
  localparam int dsDPR  = 8;
  localparam int dsDRY  = 7;
  localparam int dsSSC  = 6;
  localparam int dsPES  = 5;
  localparam int dsSDWN = 4;
  localparam int dsIDB  = 3;
  localparam int dsTM   = 2;
  localparam int dsBOT  = 1;
  localparam int dsSLA  = 0;

  // Raw status bundle of one slave transport
  typedef struct packed {
    logic pip;
    logic mol;
    logic wrl;
    logic eot;
    logic dpr;
    logic dry;
    logic pes;
    logic idb;
    logic sdwn;
    logic tm;
    logic bot;
  } mt_stat_t;

  // Slave-select width, never narrower than one bit
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mt_ds_bank_if.sv
// Register-file side of the DS bank: slave select, AS write-1-to-clear, read images.
interface mt_ds_bank_if #(parameter int NDRV = 8);
  localparam int SELW = mt_pkg::sel_width(NDRV);

  logic [SELW-1:0] mtSEL;
  logic            asWR;
  logic [NDRV-1:0] asDATA;
  logic [15:0]     mtDS;
  logic [NDRV-1:0] mtAS;
  logic            mtIRQ;

  modport master (output mtSEL, output asWR, output asDATA,
                  input mtDS, input mtAS, input mtIRQ);
  modport slave  (input mtSEL, input asWR, input asDATA,
                  output mtDS, output mtAS, output mtIRQ);
endinterface

// File: rtl/mt_ds_slave.sv
// Per-slave flag latches and unselected DS image (SSC is filled in by the bank).
module mt_ds_slave
  import mt_pkg::*;
#(
  parameter int ERW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           ata_pulse,
  input  mt_stat_t       stat,
  input  logic [ERW-1:0] err_word,
  output logic           ata,
  output logic           sla,
  output logic [15:0]    ds_img
);

  logic last_err_q, last_err_d;
  logic last_mol_q, last_mol_d;
  logic ata_lat_q, ata_lat_d;
  logic sla_lat_q, sla_lat_d;
  logic err_nz;
  logic err_set, sla_set, ata_set;

  // Edge detection and latch next-state; a set always beats a same-cycle clear
  always_comb begin
    err_nz     = |err_word;
    err_set    = err_nz & ~last_err_q;
    sla_set    = stat.mol & ~last_mol_q;
    ata_set    = ata_pulse | err_set | sla_set;
    last_err_d = err_nz;
    last_mol_d = stat.mol;
    ata_lat_d  = ata_set ? 1'b1 : (clr ? 1'b0 : ata_lat_q);
    sla_lat_d  = sla_set ? 1'b1 : (clr ? 1'b0 : sla_lat_q);
  end

  // Flag registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_err_q <= 1'b0;
      last_mol_q <= 1'b0;
      ata_lat_q  <= 1'b0;
      sla_lat_q  <= 1'b0;
    end else begin
      last_err_q <= last_err_d;
      last_mol_q <= last_mol_d;
      ata_lat_q  <= ata_lat_d;
      sla_lat_q  <= sla_lat_d;
    end
  end

  assign ata = ata_lat_q;
  assign sla = sla_lat_q;

  // DS image from latches and live status; bits 9 and SSC stay zero here
  always_comb begin
    ds_img         = '0;
    ds_img[dsATA]  = ata_lat_q;
    ds_img[dsERR]  = err_nz;
    ds_img[dsPIP]  = stat.pip;
    ds_img[dsMOL]  = stat.mol;
    ds_img[dsWRL]  = stat.wrl;
    ds_img[dsEOT]  = stat.eot;
    ds_img[dsDPR]  = stat.dpr;
    ds_img[dsDRY]  = stat.dry;
    ds_img[dsPES]  = stat.pes;
    ds_img[dsSDWN] = stat.sdwn;
    ds_img[dsIDB]  = stat.idb;
    ds_img[dsTM]   = stat.tm;
    ds_img[dsBOT]  = stat.bot;
    ds_img[dsSLA]  = sla_lat_q;
  end

endmodule

// File: rtl/mt_ds_bank.sv
// Drive-status bank for NDRV slave transports: DS mux, attention summary, interrupt.
module mt_ds_bank
  import mt_pkg::*;
#(
  parameter int NDRV = 8,
  parameter int ERW  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mtINIT,
  input  logic [NDRV-1:0]     mtATA,
  input  logic [NDRV-1:0]     mtPIP,
  input  logic [NDRV-1:0]     mtMOL,
  input  logic [NDRV-1:0]     mtWRL,
  input  logic [NDRV-1:0]     mtEOT,
  input  logic [NDRV-1:0]     mtDPR,
  input  logic [NDRV-1:0]     mtDRY,
  input  logic [NDRV-1:0]     mtPES,
  input  logic [NDRV-1:0]     mtIDB,
  input  logic [NDRV-1:0]     mtSDWN,
  input  logic [NDRV-1:0]     mtTM,
  input  logic [NDRV-1:0]     mtBOT,
  input  logic [NDRV*ERW-1:0] mtER,
  mt_ds_bank_if.slave         bus
);

  localparam int SELW = sel_width(NDRV);
  localparam int NSLV = (NDRV > NDRV_MAX) ? NDRV_MAX : NDRV;

  logic [NDRV-1:0] ata_vec;
  logic [NDRV-1:0] sla_vec;
  logic [15:0]     ds_img [NDRV];
  logic [15:0]     ds_sel;
  logic            ssc;

  for (genvar n = 0; n < NSLV; n++) begin : g_slave
    mt_stat_t stat;
    logic     clr;

    assign stat = {mtPIP[n], mtMOL[n], mtWRL[n], mtEOT[n], mtDPR[n], mtDRY[n],
                   mtPES[n], mtIDB[n], mtSDWN[n], mtTM[n], mtBOT[n]};
    assign clr  = mtINIT | (bus.asWR & bus.asDATA[n]);

    mt_ds_slave #(.ERW(ERW)) u_slave (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .ata_pulse (mtATA[n]),
      .stat      (stat),
      .err_word  (mtER[n*ERW +: ERW]),
      .ata       (ata_vec[n]),
      .sla       (sla_vec[n]),
      .ds_img    (ds_img[n])
    );
  end

  assign ssc = |sla_vec;

  // Select the addressed slave's image; a nonexistent slave reads as all zero
  always_comb begin
    ds_sel = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (bus.mtSEL == SELW'(i)) begin
        ds_sel        = ds_img[i];
        ds_sel[dsSSC] = ssc;
      end
    end
  end

  assign bus.mtDS  = ds_sel;
  assign bus.mtAS  = ata_vec;
  assign bus.mtIRQ = |ata_vec;

endmodule

// File: tb/tb_mt_ds_bank.sv
// Directed bench for mt_ds_bank with a flag-level model checked every falling edge.
module tb_mt_ds_bank;
  localparam int N   = 6;
  localparam int ERW = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           mtINIT;
  logic [N-1:0]   mtATA, mtPIP, mtMOL, mtWRL, mtEOT, mtDPR, mtDRY;
  logic [N-1:0]   mtPES, mtIDB, mtSDWN, mtTM, mtBOT;
  logic [N*ERW-1:0] mtER;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [N-1:0] m_ata  = '0;
  logic [N-1:0] m_sla  = '0;
  logic [N-1:0] m_lerr = '0;
  logic [N-1:0] m_lmol = '0;

  mt_ds_bank_if #(.NDRV(N)) bus ();

  mt_ds_bank #(.NDRV(N), .ERW(ERW)) dut (
    .clk    (clk),
    .rst    (rst),
    .mtINIT (mtINIT),
    .mtATA  (mtATA),
    .mtPIP  (mtPIP),
    .mtMOL  (mtMOL),
    .mtWRL  (mtWRL),
    .mtEOT  (mtEOT),
    .mtDPR  (mtDPR),
    .mtDRY  (mtDRY),
    .mtPES  (mtPES),
    .mtIDB  (mtIDB),
    .mtSDWN (mtSDWN),
    .mtTM   (mtTM),
    .mtBOT  (mtBOT),
    .mtER   (mtER),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Which slaves have a nonzero error word right now
  function automatic logic [N-1:0] err_now();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (mtER[i*ERW +: ERW] != '0);
    return v;
  endfunction

  // Which slaves are being cleared this cycle
  function automatic logic [N-1:0] clr_mask();
    return {N{mtINIT}} | ({N{bus.asWR}} & bus.asDATA);
  endfunction

  // Expected DS word assembled field by field from the bit map
  function automatic logic [15:0] exp_ds();
    int s;
    logic [15:0] r;
    s = int'(bus.mtSEL);
    r = '0;
    if (s < N)
      r = {m_ata[s], (mtER[s*ERW +: ERW] != '0), mtPIP[s], mtMOL[s], mtWRL[s], mtEOT[s],
           1'b0, mtDPR[s], mtDRY[s], |m_sla, mtPES[s], mtSDWN[s], mtIDB[s], mtTM[s],
           mtBOT[s], m_sla[s]};
    return r;
  endfunction

  // Set/clear view of the flags: events OR in, clears mask out, events win
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ata  <= '0;
      m_sla  <= '0;
      m_lerr <= '0;
      m_lmol <= '0;
    end else begin
      m_ata  <= (m_ata & ~clr_mask()) | mtATA | (err_now() & ~m_lerr) | (mtMOL & ~m_lmol);
      m_sla  <= (m_sla & ~clr_mask()) | (mtMOL & ~m_lmol);
      m_lerr <= err_now();
      m_lmol <= mtMOL;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Continuous comparison against the model on every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("model_ds", bus.mtDS, exp_ds());
      checkOutput("model_as", 16'(bus.mtAS), 16'(m_ata));
      checkOutput("model_irq", 16'(bus.mtIRQ), 16'(|m_ata));
    end
  end

  initial begin
    rst = 1'b1; mtINIT = 1'b0;
    mtATA = '0; mtPIP = '0; mtMOL = '0; mtWRL = '0; mtEOT = '0; mtDPR = '0;
    mtDRY = '0; mtPES = '0; mtIDB = '0; mtSDWN = '0; mtTM = '0; mtBOT = '0;
    mtER = '0;
    bus.mtSEL = '0; bus.asWR = 1'b0; bus.asDATA = '0;
    #2 rst = 1'b0;
    chk_en = 1'b1;
    applyStimulus(2);
    checkOutput("reset_ds", bus.mtDS, 16'h0000);
    checkOutput("reset_as", 16'(bus.mtAS), 16'h0000);
    checkOutput("reset_irq", 16'(bus.mtIRQ), 16'h0000);
    rst = 1'b1;
    applyStimulus(1);

    // Slave 3 comes on-line
    mtMOL[3] = 1'b1; mtDPR[3] = 1'b1; bus.mtSEL = 3'd3;
    #1 checkOutput("online_live", bus.mtDS, 16'h1100);
    applyStimulus(1);
    checkOutput("online_ds", bus.mtDS, 16'h9141);
    checkOutput("online_as", 16'(bus.mtAS), 16'h0008);
    checkOutput("online_irq", 16'(bus.mtIRQ), 16'h0001);
    bus.asWR = 1'b1; bus.asDATA = 6'h08;
    applyStimulus(1);
    bus.asWR = 1'b0; bus.asDATA = '0;
    checkOutput("online_clr_ds", bus.mtDS, 16'h1100);
    checkOutput("online_clr_as", 16'(bus.mtAS), 16'h0000);

    // Persistent error on slave 5 sets ATA once
    mtER[5*ERW +: ERW] = 16'h0004; bus.mtSEL = 3'd5;
    applyStimulus(1);
    checkOutput("err_ds", bus.mtDS, 16'hC000);
    checkOutput("err_as", 16'(bus.mtAS), 16'h0020);
    applyStimulus(9);
    checkOutput("err_hold_as", 16'(bus.mtAS), 16'h0020);
    bus.asWR = 1'b1; bus.asDATA = 6'h20;
    applyStimulus(1);
    bus.asWR = 1'b0; bus.asDATA = '0;
    checkOutput("err_clr_as", 16'(bus.mtAS), 16'h0000);
    checkOutput("err_clr_ds", bus.mtDS, 16'h4000);
    applyStimulus(3);
    checkOutput("err_no_reset", 16'(bus.mtAS), 16'h0000);
    mtER = '0;
    applyStimulus(1);

    // Set beats a simultaneous clear
    mtATA[2] = 1'b1; bus.asWR = 1'b1; bus.asDATA = 6'h04;
    applyStimulus(1);
    mtATA = '0; bus.asWR = 1'b0; bus.asDATA = '0;
    checkOutput("set_wins", 16'(bus.mtAS), 16'h0004);
    bus.asWR = 1'b1; bus.asDATA = 6'h04;
    applyStimulus(1);
    bus.asWR = 1'b0; bus.asDATA = '0;
    checkOutput("second_clr", 16'(bus.mtAS), 16'h0000);

    // Controller init clears slaves 1 and 5
    mtMOL[1] = 1'b1; mtATA[5] = 1'b1; bus.mtSEL = 3'd1;
    applyStimulus(1);
    mtATA = '0;
    checkOutput("two_as", 16'(bus.mtAS), 16'h0022);
    checkOutput("two_ds", bus.mtDS, 16'h9041);
    mtINIT = 1'b1;
    applyStimulus(1);
    mtINIT = 1'b0;
    checkOutput("init_as", 16'(bus.mtAS), 16'h0000);
    checkOutput("init_ds", bus.mtDS, 16'h1000);
    checkOutput("init_irq", 16'(bus.mtIRQ), 16'h0000);

    // Asynchronous reset between clock edges
    mtATA[4] = 1'b1;
    applyStimulus(1);
    mtATA = '0;
    checkOutput("pre_rst_as", 16'(bus.mtAS), 16'h0010);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_as", 16'(bus.mtAS), 16'h0000);
    checkOutput("async_irq", 16'(bus.mtIRQ), 16'h0000);
    checkOutput("async_ds", bus.mtDS, 16'h1000);
    applyStimulus(1);
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("rerise_as", 16'(bus.mtAS), 16'h000A);
    checkOutput("rerise_ds", bus.mtDS, 16'h9041);

    // Nonexistent slaves read zero
    bus.mtSEL = 3'd7;
    #1 checkOutput("sel7_ds", bus.mtDS, 16'h0000);
    bus.mtSEL = 3'd6;
    #1 checkOutput("sel6_ds", bus.mtDS, 16'h0000);
    mtINIT = 1'b1;
    applyStimulus(1);
    mtINIT = 1'b0;
    bus.mtSEL = 3'd0; mtBOT[0] = 1'b1; mtDRY[0] = 1'b1;
    #1 checkOutput("bot_dry_ds", bus.mtDS, 16'h0082);

    // Remaining live status fields on slave 2
    bus.mtSEL = 3'd2;
    mtPIP[2] = 1'b1; mtWRL[2] = 1'b1; mtEOT[2] = 1'b1; mtPES[2] = 1'b1;
    mtSDWN[2] = 1'b1; mtIDB[2] = 1'b1; mtTM[2] = 1'b1;
    #1 checkOutput("fields_ds", bus.mtDS, 16'h2C3C);
    applyStimulus(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
